// File: rtl/magnetron_pkg.sv
// Shared types and helpers for the magnetron power controller.
package magnetron_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } mag_state_e;

  // Requested levels beyond the top of the scale run at full power.
  function automatic int unsigned clamp_pwr(input int unsigned level,
                                            input int unsigned max_level);
    return (level > max_level) ? max_level : level;
  endfunction

endpackage

// File: rtl/magnetron_tick_gen.sv
// One-second tick divider: restartable, holds its count while disabled.
module magnetron_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/magnetron_ctrl_pwr.sv
// Magnetron cook controller: button/door FSM, seconds countdown and
// power-level duty cycling over a PWR_LEVELS-second window.
//
//   state | meaning
//   IDLE  | no cook programmed, magnetron off
//   READY | time and power loaded, waiting for start with door closed
//   COOK  | counting down, magnetron follows the duty window
//   PAUSE | cook suspended by door or stop, countdown held
//   DONE  | countdown expired, waiting for any button or door open
module magnetron_ctrl_pwr
  import magnetron_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned TIME_W        = 12,
  parameter int unsigned PWR_LEVELS    = 10,
  parameter int unsigned PWR_W         = $clog2(PWR_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              mag_on,
  output logic [TIME_W-1:0] remaining,
  output logic [2:0]        state,
  output logic              done
);

  localparam logic [PWR_W-1:0] LAST_POS = PWR_W'(PWR_LEVELS - 1);

  mag_state_e        state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PWR_W-1:0]  pwr_q, pwr_d;
  logic [PWR_W-1:0]  pos_q, pos_d;
  logic              start_q, stop_q;
  logic              mag_q, mag_d;
  logic              done_q, done_d;

  logic              start_ev, stop_ev, door_open, halt;
  logic              tick, tick_restart, tick_en;
  logic [PWR_W-1:0]  pwr_clamped;

  assign start_ev    = start_q && !startn;
  assign stop_ev     = stop_q && !stopn;
  assign door_open   = !door_closed;
  assign halt        = door_open || stop_ev;
  assign pwr_clamped = PWR_W'(clamp_pwr(32'(power_in), PWR_LEVELS));

  magnetron_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (tick_restart),
    .en      (tick_en),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      pwr_q   <= '0;
      pos_q   <= '0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pwr_q   <= pwr_d;
      pos_q   <= pos_d;
      start_q <= startn;
      stop_q  <= stopn;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pwr_d   = pwr_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    if (!clearn) begin
      state_d = IDLE;
      rem_d   = '0;
      pwr_d   = '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (load) begin
            if (time_in != '0) begin
              state_d = READY;
              rem_d   = time_in;
              pwr_d   = pwr_clamped;
            end else begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end else if (state_q == READY && start_ev && !stop_ev && door_closed) begin
            state_d = COOK;
            pos_d   = '0;
          end
        end
        COOK: begin
          // A halt in the same cycle as a tick swallows the tick.
          if (halt) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (rem_q <= TIME_W'(1)) begin
              rem_d   = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - TIME_W'(1);
            end
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + PWR_W'(1);
          end
        end
        PAUSE: begin
          if (stop_ev) begin
            state_d = IDLE;
            rem_d   = '0;
          end else if (start_ev && door_closed) begin
            state_d = COOK;
          end
        end
        DONE: begin
          if (stop_ev || start_ev || door_open) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tick_en      = (state_q == COOK) && clearn && !halt;
    tick_restart = (state_q != COOK) && (state_d == COOK);
    // door_closed term keeps the drive off even if the FSM were to misbehave.
    mag_d        = (state_d == COOK) && door_closed && (pos_d < pwr_d);
  end

  assign mag_on    = mag_q;
  assign remaining = rem_q;
  assign state     = state_q;
  assign done      = done_q;

endmodule

// File: tb/tb_magnetron_ctrl_pwr.sv
// Directed bench for magnetron_ctrl_pwr with 4 ticks/second and 4 power levels.
module tb_magnetron_ctrl_pwr;

  localparam int TPS = 4;
  localparam int PL  = 4;
  localparam int TW  = 12;
  localparam int PW  = 3;
  localparam int NV  = 22;

  localparam int S_IDLE  = 0;
  localparam int S_READY = 1;
  localparam int S_COOK  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic          clk = 1'b0;
  logic          rst, startn, stopn, clearn, door_closed, load;
  logic [TW-1:0] time_in;
  logic [PW-1:0] power_in;
  logic          mag_on;
  logic [TW-1:0] remaining;
  logic [2:0]    state;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rst, startn, stopn, clearn, door, load;
    logic [TW-1:0] tin;
    logic [PW-1:0] pin;
    logic [2:0]    e_state;
    logic          e_mag;
    logic [TW-1:0] e_rem;
    logic          e_done;
  } vec_t;

  vec_t vecs[NV];

  magnetron_ctrl_pwr #(
    .TICKS_PER_SEC (TPS),
    .TIME_W        (TW),
    .PWR_LEVELS    (PL),
    .PWR_W         (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .load        (load),
    .time_in     (time_in),
    .power_in    (power_in),
    .mag_on      (mag_on),
    .remaining   (remaining),
    .state       (state),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int r, input int s, input int p, input int c,
                              input int d, input int l, input int t, input int pw,
                              input int es, input int em, input int er, input int ed);
    vec_t v;
    v.rst = 1'(r); v.startn = 1'(s); v.stopn = 1'(p); v.clearn = 1'(c);
    v.door = 1'(d); v.load = 1'(l); v.tin = TW'(t); v.pin = PW'(pw);
    v.e_state = 3'(es); v.e_mag = 1'(em); v.e_rem = TW'(er); v.e_done = 1'(ed);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int t, input int p);
    load = 1'b1; time_in = TW'(t); power_in = PW'(p);
    step;
    load = 1'b0;
    chk("load_state", int'(state), (t != 0) ? S_READY : S_IDLE);
    chk("load_rem", int'(remaining), t);
  endtask

  task automatic do_start;
    startn = 1'b0;
    step;
    startn = 1'b1;
  endtask

  task automatic run_cook(input int budget, output int on_cnt, output int done_at,
                          output int done_cnt, output int rem4, output int rem8);
    on_cnt = int'(mag_on); done_at = -1; done_cnt = 0; rem4 = -1; rem8 = -1;
    for (int i = 1; i <= budget; i++) begin
      step;
      if (mag_on) on_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 4) rem4 = int'(remaining);
      if (i == 8) rem8 = int'(remaining);
    end
  endtask

  initial begin
    int on_cnt, done_at, done_cnt, rem4, rem8;
    rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    load = 1'b0; time_in = '0; power_in = '0;

    //            rst st sp cl dr ld tin pin | state  mag rem done
    vecs[0]  = mk(1, 1, 1, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 1, 1, 1, 0, 2,  S_IDLE,  0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 1, 1, 1, 7, 7,  S_READY, 0, 7, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 0,  S_READY, 0, 7, 0);
    vecs[5]  = mk(0, 0, 1, 1, 1, 0, 0, 0,  S_READY, 0, 7, 0);
    vecs[6]  = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_READY, 0, 7, 0);
    vecs[7]  = mk(0, 0, 1, 1, 1, 0, 0, 0,  S_COOK,  1, 7, 0);
    vecs[8]  = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_COOK,  1, 7, 0);
    vecs[9]  = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_COOK,  1, 7, 0);
    vecs[10] = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_COOK,  1, 7, 0);
    vecs[11] = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_COOK,  1, 6, 0);
    vecs[12] = mk(0, 1, 1, 1, 1, 1, 3, 1,  S_COOK,  1, 6, 0);
    vecs[13] = mk(0, 1, 1, 0, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[14] = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[16] = mk(0, 1, 1, 1, 1, 1, 2, 0,  S_READY, 0, 2, 0);
    vecs[17] = mk(0, 0, 1, 1, 1, 0, 0, 0,  S_COOK,  0, 2, 0);
    vecs[18] = mk(0, 1, 0, 1, 1, 0, 0, 0,  S_PAUSE, 0, 2, 0);
    vecs[19] = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_PAUSE, 0, 2, 0);
    vecs[20] = mk(0, 1, 0, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);
    vecs[21] = mk(0, 1, 1, 1, 1, 0, 0, 0,  S_IDLE,  0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; startn = vecs[i].startn; stopn = vecs[i].stopn;
      clearn = vecs[i].clearn; door_closed = vecs[i].door; load = vecs[i].load;
      time_in = vecs[i].tin; power_in = vecs[i].pin;
      step;
      chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].e_state));
      chk($sformatf("vec%0d_mag", i), int'(mag_on), int'(vecs[i].e_mag));
      chk($sformatf("vec%0d_rem", i), int'(remaining), int'(vecs[i].e_rem));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
    end
    load = 1'b0; time_in = '0; power_in = '0;

    // 3 s at full power: 12 on-cycles, done once at the 12th edge.
    do_load(3, 4);
    do_start;
    chk("a_entry_rem", int'(remaining), 3);
    run_cook(30, on_cnt, done_at, done_cnt, rem4, rem8);
    chk("a_on_cycles", on_cnt, 12);
    chk("a_done_at", done_at, 12);
    chk("a_done_count", done_cnt, 1);
    chk("a_rem_after_1s", rem4, 2);
    chk("a_rem_after_2s", rem8, 1);
    chk("a_final_state", int'(state), S_DONE);
    chk("a_final_rem", int'(remaining), 0);
    stopn = 1'b0; step; stopn = 1'b1;
    chk("a_exit_state", int'(state), S_IDLE);
    step;

    // 5 s at power 2: per-second pattern 1,1,0,0,1.
    do_load(5, 2);
    do_start;
    chk("b_mag_c0", int'(mag_on), 1);
    for (int i = 1; i < 20; i++) begin
      step;
      chk($sformatf("b_mag_c%0d", i), int'(mag_on), (((i / TPS) % PL) < 2) ? 1 : 0);
      if (done) chk("b_early_done", i, 20);
    end
    step;
    chk("b_done_c20", int'(done), 1);
    chk("b_state_c20", int'(state), S_DONE);
    startn = 1'b0; step; startn = 1'b1;
    chk("b_exit_state", int'(state), S_IDLE);
    step;

    // Power 7 clamps to 4: continuously on for 4 s.
    do_load(4, 7);
    do_start;
    run_cook(24, on_cnt, done_at, done_cnt, rem4, rem8);
    chk("c_on_cycles", on_cnt, 16);
    chk("c_done_at", done_at, 16);
    door_closed = 1'b0; step;
    chk("c_exit_state", int'(state), S_IDLE);
    door_closed = 1'b1; step;

    // Door opened mid-cook, then closed and restarted.
    do_load(4, 4);
    do_start;
    for (int i = 1; i <= 6; i++) step;
    chk("d_rem_before_door", int'(remaining), 3);
    door_closed = 1'b0; step;
    chk("d_pause_state", int'(state), S_PAUSE);
    chk("d_pause_mag", int'(mag_on), 0);
    chk("d_pause_rem", int'(remaining), 3);
    startn = 1'b0; step; startn = 1'b1;
    chk("d_start_door_open", int'(state), S_PAUSE);
    chk("d_mag_door_open", int'(mag_on), 0);
    door_closed = 1'b1; step;
    chk("d_closed_state", int'(state), S_PAUSE);
    do_start;
    chk("d_resume_state", int'(state), S_COOK);
    chk("d_resume_rem", int'(remaining), 3);
    run_cook(20, on_cnt, done_at, done_cnt, rem4, rem8);
    chk("d_on_cycles", on_cnt, 12);
    chk("d_done_at", done_at, 12);
    chk("d_done_count", done_cnt, 1);
    stopn = 1'b0; step; stopn = 1'b1; step;

    // Reset mid-cook.
    do_load(6, 4);
    do_start;
    for (int i = 1; i <= 5; i++) step;
    chk("e_rem_before_rst", int'(remaining), 5);
    rst = 1'b1; step; rst = 1'b0;
    chk("e_rst_state", int'(state), S_IDLE);
    chk("e_rst_rem", int'(remaining), 0);
    chk("e_rst_mag", int'(mag_on), 0);
    chk("e_rst_done", int'(done), 0);
    do_start;
    chk("e_start_after_rst", int'(state), S_IDLE);
    step;

    // Start and stop together on a tick cycle: stop wins, no decrement.
    do_load(5, 4);
    do_start;
    for (int i = 1; i <= 3; i++) step;
    startn = 1'b0; stopn = 1'b0; step;
    startn = 1'b1; stopn = 1'b1;
    chk("f_both_state", int'(state), S_PAUSE);
    chk("f_both_rem", int'(remaining), 5);
    chk("f_both_mag", int'(mag_on), 0);
    step;
    do_start;
    chk("f_resume_state", int'(state), S_COOK);
    for (int i = 1; i <= 3; i++) step;
    chk("f_rem_restarted", int'(remaining), 5);
    step;
    chk("f_rem_tick", int'(remaining), 4);
    stopn = 1'b0; step; stopn = 1'b1; step;
    chk("f_stop_pause", int'(state), S_PAUSE);
    stopn = 1'b0; step; stopn = 1'b1;
    chk("f_stop_idle", int'(state), S_IDLE);
    chk("f_stop_rem", int'(remaining), 0);
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
